out_port_uart_tx: RTL
=====================

OUT_PORT_UART_TX -- requirements
Module: out_port_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte-buffer depth; power of two, at least 2.
REQ-003 CLK100MHZ  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 port_in  input  8  byte from the processor OUT port; treated as stable between rising edges.
REQ-006 tx  output  1  serial line, 8N1, idle high, registered.
REQ-007 busy  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-008 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-009 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, 0..FIFO_DEPTH.

Function
REQ-010 Change detect: the block holds last_in. On any edge where port_in != last_in, it loads last_in with port_in and issues a push of port_in.
REQ-011 A byte equal to last_in is never pushed; repeated writes of the same value produce no frame.
REQ-012 If a push occurs while fifo_count == FIFO_DEPTH, the byte is dropped, the FIFO is unchanged, and overflow sets on that edge.
REQ-013 overflow remains set until reset.
REQ-014 A push and a pop on the same edge both take effect; fifo_count is unchanged.
REQ-015 The FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: tx = 1. If fifo_count > 0, on the next edge: pop the head into shift_reg, set tx = 0, clear the baud counter and bit index, go to START.
REQ-018 START: tx stays 0 for CLKS_PER_BIT cycles. Then: tx = shift_reg[0], go to DATA.
REQ-019 DATA: each bit is held for CLKS_PER_BIT cycles, LSB first, over 8 bits. After bit 7: tx = 1, go to STOP.
REQ-020 STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-021 Latency: tx falls on the second rising edge after port_in changes (edge 1: push; edge 2: pop and start bit), provided the FSM is in IDLE.
REQ-022 Back-to-back frames: if the FIFO is non-empty on return to IDLE, exactly one extra high cycle separates the stop bit from the next start bit.
REQ-023 Frame length is 10*CLKS_PER_BIT cycles, plus the one IDLE cycle.
REQ-024 busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-025 While rst is high, immediately and independently of the clock: tx = 1, busy = 0, overflow = 0, fifo_count = 0, state = IDLE, pointers = 0, baud counter = 0, bit index = 0, last_in = 0x00 (matching the processor OUT reset value).
REQ-026 Reset asserted mid-frame aborts the frame: tx returns high with no stop bit, and queued bytes are discarded.
REQ-027 After rst deasserts, a port_in value other than 0x00 is pushed on the first rising edge.

Structure
REQ-028 A shared package holds the FSM state enum (IDLE, START, DATA, STOP) and the default constants CLKS_PER_BIT_DEFAULT = 868 and FIFO_DEPTH_DEFAULT = 4.
REQ-029 The FIFO is a sub-module, byte_fifo, parameterised by depth. It has push, pop, din, dout, count, full and empty, and uses the same clock and reset.
REQ-030 The change detector, baud counter and FSM live in out_port_uart_tx; there are no other sub-modules.

Verification
REQ-031 The bench runs with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
REQ-032 Single byte: port_in 0x00 -> 0xA5 -> tx low at edge 2, then bits 1,0,1,0,0,1,0,1 each for 4 cycles, stop high, busy low 42 cycles after the change.
REQ-033 Repeat suppression: port_in 0x3C held for 100 cycles, then rewritten as 0x3C -> exactly one frame, fifo_count peaks at 1.
REQ-034 Overflow: port_in steps 0x01, 0x02, 0x03, 0x04, 0x05, 0x06 on consecutive edges -> 0x01 pops immediately, 0x02..0x05 fill the FIFO (count 4), 0x06 is dropped, overflow = 1. Five frames carrying 0x01..0x05 follow, each separated by one idle-high cycle.
REQ-035 Simultaneous push/pop: with the FIFO holding 1 byte and the FSM reaching IDLE, a new port_in change on the pop edge -> fifo_count stays 1 and both bytes transmit in order.
REQ-036 Reset mid-frame: rst asserted during DATA bit 3 of 0xF0 -> tx = 1 asynchronously, fifo_count = 0, overflow = 0. After release with port_in = 0xF0, a full 0xF0 frame starts at edge 2.
REQ-037 Wrap-around: 12 distinct bytes sent with gaps -> pointers wrap three times and all 12 bytes are received correctly by the bench UART model.

Source files
------------

// File: rtl/out_port_uart_tx_pkg.sv
// Shared types and default constants for the OUT-port UART transmitter.
package out_port_uart_tx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned FIFO_DEPTH_DEFAULT   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with show-ahead head output; pushes into a full FIFO are ignored.
module byte_fifo
    import out_port_uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_uart_tx.sv
// Turns changes on a processor OUT port into queued 8N1 serial frames.
module out_port_uart_tx
    import out_port_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic                        CLK100MHZ,
    input  logic                        rst,
    input  logic [7:0]                  port_in,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic [7:0]        last_in;
    logic              push;
    logic              pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    assign push = (port_in != last_in);
    assign pop  = (state == IDLE) && !fifo_empty;
    assign busy = (state != IDLE) || (fifo_count != '0);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK100MHZ),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (port_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Change detector and sticky overflow flag.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            last_in  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                last_in <= port_in;
            end
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame FSM: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_dout;
                        tx        <= 1'b0;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
